// File: rtl/bp_tournament_pkg.sv
// Shared types and counter helpers for the tournament direction predictor.
// Snapshot fields are sized for the widest supported configuration.
package bp_tournament_pkg;

    localparam int CTR_MAX_W  = 8;
    localparam int SNAP_PC_W  = 32;
    localparam int SNAP_IDX_W = 16;

    typedef enum logic [1:0] {
        LOCAL  = 2'd0,
        GLOBAL = 2'd1,
        TOURN  = 2'd2
    } mode_e;

    typedef struct packed {
        logic [SNAP_PC_W-1:0]  pc;
        logic [SNAP_IDX_W-1:0] ghist;
        logic [SNAP_IDX_W-1:0] p_idx;
        logic [SNAP_IDX_W-1:0] g_idx;
        logic                  p_dir;
        logic                  g_dir;
        logic                  fin;
    } snap_t;

    function automatic logic [CTR_MAX_W-1:0] ctr_init(input int unsigned w);
        return CTR_MAX_W'((1 << (w - 1)) - 1);
    endfunction

    function automatic logic [CTR_MAX_W-1:0] ctr_next(
        input logic [CTR_MAX_W-1:0] c,
        input int unsigned          w,
        input logic                 taken
    );
        logic [CTR_MAX_W-1:0] top;
        top = CTR_MAX_W'((1 << w) - 1);
        if (taken) return (c == top) ? c : c + CTR_MAX_W'(1);
        return (c == '0) ? c : c - CTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/bp_sat_ctr_table.sv
// Array of saturating counters: async read of the direction bit,
// one training write port per cycle.
module bp_sat_ctr_table
    import bp_tournament_pkg::*;
#(
    parameter int IDX_W = 5,
    parameter int CTR_W = 2
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] INIT = CTR_W'(ctr_init(CTR_W));

    logic [CTR_W-1:0] mem_q [DEPTH];
    logic [CTR_W-1:0] mem_d [DEPTH];

    assign rd_taken_o = mem_q[rd_idx_i][CTR_W-1];

    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) begin
            mem_d[wr_idx_i] = CTR_W'(ctr_next(CTR_MAX_W'(mem_q[wr_idx_i]),
                                              CTR_W, wr_taken_i));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/bp_tournament_predictor.sv
// Tournament (PShare/GShare + chooser) direction predictor with
// speculative global history and an in-order snapshot queue.
module bp_tournament_predictor
    import bp_tournament_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int LHT_IDXW  = 5,
    parameter int LH_W      = 5,
    parameter int GH_W      = 5,
    parameter int META_IDXW = 5,
    parameter int CTR_W     = 2,
    parameter int MODE      = 2,
    parameter int INFL_D    = 4
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            pred_v_i,
    input  logic [PC_W-1:0] pred_pc_i,
    output logic            pred_ready_o,
    output logic            pred_v_o,
    output logic            pred_taken_o,
    input  logic            res_v_i,
    input  logic            res_taken_i,
    output logic            res_mispred_o,
    output logic            res_orphan_o
);

    localparam int QW = $clog2(INFL_D);
    localparam int LHT_D = 2 ** LHT_IDXW;
    localparam mode_e MODE_E = mode_e'(MODE);

    logic [LH_W-1:0] lht_q [LHT_D];
    logic [LH_W-1:0] lht_d [LHT_D];
    logic [GH_W-1:0] ghist_q, ghist_d;
    snap_t           q_mem_q [INFL_D];
    snap_t           q_mem_d [INFL_D];
    logic [QW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [QW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [QW:0]     cnt_q, cnt_d;
    logic            pred_v_q, pred_v_d;
    logic            pred_taken_q, pred_taken_d;
    logic            orphan_q, orphan_d;

    logic [LHT_IDXW-1:0]  rq_lidx, res_lidx;
    logic [LH_W-1:0]      rq_pidx;
    logic [GH_W-1:0]      rq_gidx, head_gh;
    logic [META_IDXW-1:0] rq_midx, res_midx;
    logic                 p_dir, g_dir, m_sel, pred_dir;
    logic                 empty, full, do_res, mispred, accept;
    snap_t                head, snap;

    assign rq_lidx = LHT_IDXW'(pred_pc_i >> 2);
    assign rq_pidx = lht_q[rq_lidx] ^ LH_W'(pred_pc_i >> 2);
    assign rq_gidx = ghist_q ^ GH_W'(pred_pc_i >> 2);
    assign rq_midx = META_IDXW'(pred_pc_i >> 2);

    assign head     = q_mem_q[rd_ptr_q];
    assign head_gh  = GH_W'(head.ghist);
    assign res_lidx = LHT_IDXW'(head.pc >> 2);
    assign res_midx = META_IDXW'(head.pc >> 2);

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (QW+1)'(INFL_D));
    assign do_res  = res_v_i && !empty;
    assign mispred = do_res && (head.fin != res_taken_i);
    // A correct resolve frees a slot in the same cycle it is consumed
    assign pred_ready_o = !mispred && (!full || do_res);
    assign accept  = pred_v_i && pred_ready_o;

    bp_sat_ctr_table #(.IDX_W(LH_W), .CTR_W(CTR_W)) u_psh (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .rd_idx_i   (rq_pidx),
        .rd_taken_o (p_dir),
        .wr_en_i    (do_res),
        .wr_idx_i   (LH_W'(head.p_idx)),
        .wr_taken_i (res_taken_i)
    );

    bp_sat_ctr_table #(.IDX_W(GH_W), .CTR_W(CTR_W)) u_gsh (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .rd_idx_i   (rq_gidx),
        .rd_taken_o (g_dir),
        .wr_en_i    (do_res),
        .wr_idx_i   (GH_W'(head.g_idx)),
        .wr_taken_i (res_taken_i)
    );

    bp_sat_ctr_table #(.IDX_W(META_IDXW), .CTR_W(CTR_W)) u_meta (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .rd_idx_i   (rq_midx),
        .rd_taken_o (m_sel),
        .wr_en_i    (do_res && (head.p_dir != head.g_dir)),
        .wr_idx_i   (res_midx),
        .wr_taken_i (head.g_dir == res_taken_i)
    );

    always_comb begin
        unique case (MODE_E)
            LOCAL:   pred_dir = p_dir;
            GLOBAL:  pred_dir = g_dir;
            default: pred_dir = m_sel ? g_dir : p_dir;
        endcase
    end

    always_comb begin
        snap = '{pc:    SNAP_PC_W'(pred_pc_i),
                 ghist: SNAP_IDX_W'(ghist_q),
                 p_idx: SNAP_IDX_W'(rq_pidx),
                 g_idx: SNAP_IDX_W'(rq_gidx),
                 p_dir: p_dir,
                 g_dir: g_dir,
                 fin:   pred_dir};
    end

    always_comb begin
        lht_d        = lht_q;
        ghist_d      = ghist_q;
        q_mem_d      = q_mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        pred_v_d     = accept;
        pred_taken_d = accept && pred_dir;
        orphan_d     = orphan_q || (res_v_i && empty);

        if (do_res) begin
            lht_d[res_lidx] = {lht_q[res_lidx][LH_W-2:0], res_taken_i};
            rd_ptr_d = rd_ptr_q + QW'(1);
        end
        if (accept) begin
            q_mem_d[wr_ptr_q] = snap;
            wr_ptr_d = wr_ptr_q + QW'(1);
            ghist_d  = {ghist_q[GH_W-2:0], pred_dir};
        end
        cnt_d = cnt_q + (QW+1)'(accept) - (QW+1)'(do_res);
        // Repair history from the mispredicted branch and drop younger work
        if (mispred) begin
            ghist_d  = {head_gh[GH_W-2:0], res_taken_i};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < LHT_D; i++) lht_q[i] <= '0;
            for (int i = 0; i < INFL_D; i++) q_mem_q[i] <= '0;
            ghist_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            pred_v_q     <= 1'b0;
            pred_taken_q <= 1'b0;
            orphan_q     <= 1'b0;
        end else begin
            lht_q        <= lht_d;
            q_mem_q      <= q_mem_d;
            ghist_q      <= ghist_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            pred_v_q     <= pred_v_d;
            pred_taken_q <= pred_taken_d;
            orphan_q     <= orphan_d;
        end
    end

    assign pred_v_o      = pred_v_q;
    assign pred_taken_o  = pred_taken_q;
    assign res_mispred_o = mispred;
    assign res_orphan_o  = orphan_q;

endmodule

// File: tb/tb_bp_tournament_predictor.sv
// Scoreboard bench for bp_tournament_predictor against a behavioural
// model of the tables, histories and in-flight queue.
module tb_bp_tournament_predictor;

    localparam int CTR_W  = 2;
    localparam int INFL_D = 4;
    localparam int IM     = 31;
    localparam int CMAX   = (1 << CTR_W) - 1;
    localparam int HALF   = 1 << (CTR_W - 1);

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        pred_v_i = 1'b0;
    logic [31:0] pred_pc_i = '0;
    logic        res_v_i = 1'b0;
    logic        res_taken_i = 1'b0;
    logic        pred_ready_o, pred_v_o, pred_taken_o;
    logic        res_mispred_o, res_orphan_o;

    always #5 clk = ~clk;

    bp_tournament_predictor dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .pred_v_i      (pred_v_i),
        .pred_pc_i     (pred_pc_i),
        .pred_ready_o  (pred_ready_o),
        .pred_v_o      (pred_v_o),
        .pred_taken_o  (pred_taken_o),
        .res_v_i       (res_v_i),
        .res_taken_i   (res_taken_i),
        .res_mispred_o (res_mispred_o),
        .res_orphan_o  (res_orphan_o)
    );

    typedef struct {
        int pc;
        int gh;
        int pidx;
        int gidx;
        bit pd;
        bit gd;
        bit fin;
    } ms_t;

    int  pt [32];
    int  gt [32];
    int  mt [32];
    int  lht [32];
    int  gh;
    bit  orph;
    ms_t mq [$];
    bit [1:0] sb [$];

    int n_err = 0;
    int n_chk = 0;
    bit last_ready, last_mis, last_taken;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int c, input bit t);
        if (t) return (c == CMAX) ? c : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            pt[i] = HALF - 1;
            gt[i] = HALF - 1;
            mt[i] = HALF - 1;
            lht[i] = 0;
        end
        gh = 0;
        orph = 0;
        mq.delete();
        sb.delete();
    endtask

    task automatic cyc(input bit pv, input int pc, input bit rv, input bit rt);
        int  cnt, li, pi, gi, mi;
        bit  do_res, mis, rdy, acc, pd, gd, fin;
        ms_t s;
        bit [1:0] e;
        @(negedge clk);
        pred_v_i = pv;
        pred_pc_i = pc;
        res_v_i = rv;
        res_taken_i = rt;
        cnt = mq.size();
        do_res = rv && (cnt > 0);
        mis = do_res && (mq[0].fin != rt);
        rdy = !mis && ((cnt < INFL_D) || do_res);
        #1;
        last_ready = pred_ready_o;
        last_mis = res_mispred_o;
        check("ready", 32'(pred_ready_o), 32'(rdy));
        check("mispred", 32'(res_mispred_o), 32'(mis));
        li = (pc >> 2) & IM;
        mi = li;
        pi = (lht[li] ^ (pc >> 2)) & IM;
        gi = (gh ^ (pc >> 2)) & IM;
        pd = pt[pi] >= HALF;
        gd = gt[gi] >= HALF;
        fin = (mt[mi] >= HALF) ? gd : pd;
        acc = pv && rdy;
        if (do_res) begin
            s = mq.pop_front();
            pt[s.pidx] = sat(pt[s.pidx], rt);
            gt[s.gidx] = sat(gt[s.gidx], rt);
            li = (s.pc >> 2) & IM;
            lht[li] = ((lht[li] << 1) | int'(rt)) & IM;
            if (s.pd != s.gd) begin
                mi = (s.pc >> 2) & IM;
                mt[mi] = sat(mt[mi], s.gd == rt);
            end
            if (mis) begin
                mq.delete();
                gh = ((s.gh << 1) | int'(rt)) & IM;
            end
        end
        if (rv && cnt == 0) orph = 1;
        if (acc) begin
            s.pc = pc; s.gh = gh; s.pidx = pi; s.gidx = gi;
            s.pd = pd; s.gd = gd; s.fin = fin;
            mq.push_back(s);
            gh = ((gh << 1) | int'(fin)) & IM;
        end
        sb.push_back({acc, acc & fin});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        last_taken = pred_taken_o;
        check("pred_v", 32'(pred_v_o), 32'(e[1]));
        check("pred_taken", 32'(pred_taken_o), 32'(e[0]));
        check("orphan", 32'(res_orphan_o), 32'(orph));
        pred_v_i = 1'b0;
        res_v_i = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            check({tag, "_psh"}, 32'(dut.u_psh.mem_q[i]), pt[i]);
            check({tag, "_gsh"}, 32'(dut.u_gsh.mem_q[i]), gt[i]);
            check({tag, "_meta"}, 32'(dut.u_meta.mem_q[i]), mt[i]);
            check({tag, "_lht"}, 32'(dut.lht_q[i]), lht[i]);
        end
        check({tag, "_ghist"}, 32'(dut.ghist_q), gh);
        check({tag, "_cnt"}, 32'(dut.cnt_q), mq.size());
    endtask

    task automatic do_reset();
        @(negedge clk);
        pred_v_i = 1'b0;
        res_v_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        model_reset();
        #1;
        check("rst_pred_v", 32'(pred_v_o), 0);
        check("rst_pred_taken", 32'(pred_taken_o), 0);
        check("rst_orphan", 32'(res_orphan_o), 0);
        check("rst_ready", 32'(pred_ready_o), 1);
        sweep("rst");
        @(negedge clk);
        reset_n_i = 1'b1;
    endtask

    initial begin
        int sgh, rt_i;
        bit sfin;
        model_reset();
        do_reset();

        cyc(1, 32'h40, 0, 0);
        check("first_ready", 32'(last_ready), 1);
        check("first_taken", 32'(last_taken), 0);
        cyc(0, 0, 1, 1);

        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'h40, 0, 0);
            cyc(0, 0, 1, 1);
        end
        check("train_taken", 32'(last_taken), 0);
        cyc(1, 32'h40, 0, 0);
        check("trained_taken", 32'(last_taken), 1);
        check("psh_ctr_sat", 32'(dut.u_psh.mem_q[15]), 3);
        cyc(0, 0, 1, 1);
        sweep("train");

        for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 4 * i, 0, 0);
        cyc(1, 32'h110, 0, 0);
        check("full_refused", 32'(last_ready), 0);
        cyc(1, 32'h114, 1, mq[0].fin);
        check("full_res_ready", 32'(last_ready), 1);
        for (int i = 0; i < 8 && mq.size() > 0; i++) cyc(0, 0, 1, mq[0].fin);
        sweep("full");

        cyc(1, 32'h200, 0, 0);
        cyc(1, 32'h204, 0, 0);
        cyc(1, 32'h208, 0, 0);
        sgh = mq[0].gh;
        sfin = mq[0].fin;
        cyc(1, 32'h20c, 1, !sfin);
        check("mis_flag", 32'(last_mis), 1);
        check("mis_refused", 32'(last_ready), 0);
        check("mis_cnt", 32'(dut.cnt_q), 0);
        check("mis_ghist", 32'(dut.ghist_q), ((sgh << 1) | int'(!sfin)) & IM);
        sweep("mis");

        for (int i = 0; i < 400; i++) begin
            rt_i = $urandom_range(0, 3);
            cyc($urandom_range(0, 1) == 1,
                32'h40 + 4 * $urandom_range(0, 7),
                (mq.size() > 0) && ($urandom_range(0, 2) != 0),
                (rt_i == 0) ? 1'b0 : (rt_i == 1) ? 1'b1
                    : (mq.size() > 0) ? mq[0].fin : 1'b0);
        end
        sweep("rand");

        do_reset();
        cyc(0, 0, 1, 1);
        check("orphan_set", 32'(res_orphan_o), 1);
        cyc(0, 0, 0, 0);
        cyc(1, 32'h40, 0, 0);
        check("orphan_sticky", 32'(res_orphan_o), 1);
        cyc(0, 0, 1, 1);
        cyc(1, 32'h48, 0, 0);
        cyc(1, 32'h4c, 0, 0);
        do_reset();
        cyc(1, 32'h40, 0, 0);
        check("post_rst_taken", 32'(last_taken), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
